eth_phy_10g_rx_block_lock_ml: RTL and testbench
===============================================

ETH_PHY_10G_RX_BLOCK_LOCK_ML -- requirements
Module: eth_phy_10g_rx_block_lock_ml

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent 64b/66b lanes (1..8).
REQ-002 SHALL have parameter HDR_WIDTH, default 2, sync-header width per lane.
REQ-003 SHALL have parameter SH_WINDOW, default 64, valid headers required to lock and locked-window length (power of 2, 16..1024).
REQ-004 SHALL have parameter SH_INVALID_MAX, default 16, invalid headers within a locked window that cause loss of lock.
REQ-005 SHALL have parameter BITSLIP_HIGH_CYCLES, default 1, bitslip pulse width.
REQ-006 SHALL have parameter BITSLIP_LOW_CYCLES, default 8, post-slip settle cycles with headers ignored.
REQ-007 SHALL have parameter SLIP_LIMIT, default 66, consecutive slips without lock before reset request.
REQ-008 SHALL have port rx_clk  input  1  sole clock; all logic on rising edge.
REQ-009 SHALL have port rx_rst_n  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port serdes_rx_hdr  input  LANES*HDR_WIDTH  per-lane sync header, lane n at [2n+1:2n].
REQ-011 SHALL have port serdes_rx_hdr_valid  input  LANES  per-lane header qualifier (gearbox gaps).
REQ-012 SHALL have port serdes_rx_bitslip  output  LANES  per-lane bitslip request.
REQ-013 SHALL have port serdes_rx_reset_req  output  LANES  per-lane one-cycle SERDES reset request.
REQ-014 SHALL have port rx_block_lock  output  LANES  per-lane block lock.
REQ-015 SHALL have port rx_all_lock  output  1  all lanes locked.
REQ-016 SHALL have port rx_lock_loss_count  output  LANES*8  per-lane saturating lock-loss counter.

Function
REQ-017 SHALL treat a header as valid when 2'b01 or 2'b10, invalid when 2'b00 or 2'b11, and counted only in cycles where the lane's hdr_valid is 1.
REQ-018 SHALL implement per lane independent FSM: UNLOCKED, LOCKED, SLIP_HIGH, SLIP_WAIT; lanes share no state except rx_all_lock.
REQ-019 SHALL, in UNLOCKED, increment sh_cnt per counted valid header; on the counted valid header that makes SH_WINDOW consecutive, go LOCKED, clear counters and slip count.
REQ-020 SHALL, in UNLOCKED, on any counted invalid header, clear sh_cnt and go SLIP_HIGH.
REQ-021 SHALL, in LOCKED, increment sh_cnt per counted header and sh_invalid_cnt per counted invalid header.
REQ-022 SHALL, in LOCKED, when a counted invalid header brings sh_invalid_cnt to SH_INVALID_MAX, clear lock, clear counters, increment rx_lock_loss_count (saturate at 255), go SLIP_HIGH.
REQ-023 SHALL, in LOCKED, when sh_cnt completes SH_WINDOW headers without loss, clear both counters and stay LOCKED; loss check takes precedence on the same header.
REQ-024 SHALL hold serdes_rx_bitslip=1 for exactly BITSLIP_HIGH_CYCLES in SLIP_HIGH, then 0 for exactly BITSLIP_LOW_CYCLES in SLIP_WAIT ignoring headers, then enter UNLOCKED.
REQ-025 SHALL increment a per-lane slip count on each SLIP_HIGH entry; when it reaches SLIP_LIMIT pulse serdes_rx_reset_req for one cycle and clear the slip count.
REQ-026 SHALL register all outputs; rx_block_lock rises/falls on the clock edge that samples the deciding header (one-cycle latency from header input).
REQ-027 SHALL drive rx_all_lock as registered AND of rx_block_lock (one further cycle latency).
REQ-028 SHALL hold all counters and FSM state in cycles with hdr_valid=0 (except SLIP timers, which count every cycle).

Reset
REQ-029 SHALL, while rx_rst_n=0, asynchronously force every lane to UNLOCKED, all counters to 0, and all outputs to 0.
REQ-030 SHALL, on reset deassertion mid-slip or mid-window, restart from UNLOCKED with no residual bitslip or reset_req pulse.

Verification
REQ-031 Lane 0: 64 consecutive valid 2'b01 headers -> rx_block_lock[0]=1 one cycle after 64th; rx_all_lock only when all lanes locked.
REQ-032 Lane 0: 63 valid then 2'b00 -> no lock, bitslip[0]=1 for 1 cycle, 0 for 8, headers ignored during those 9 cycles.
REQ-033 Locked lane: 15 invalids within 64-header window -> stays locked; 16th invalid -> lock=0, lock_loss_count=1, bitslip pulse.
REQ-034 hdr_valid toggled 50% with all-valid headers -> lock after exactly 64 qualified headers (~128 cycles).
REQ-035 Constant 2'b11 on lane 2 -> 66 slips then serdes_rx_reset_req[2] one-cycle pulse; other lanes unaffected.
REQ-036 rx_rst_n asserted during SLIP_HIGH -> bitslip=0 immediately (async); after release lane relocks after 64 valid headers.

Source files
------------

// File: rtl/eth_phy_10g_rx_block_lock_ml_if.sv
// SERDES-facing bundle for the 10G RX block-lock: per-lane sync headers in,
// bitslip/reset requests and lock status out.
interface eth_phy_10g_rx_block_lock_ml_if #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned HDR_WIDTH = 2
);
    logic [LANES*HDR_WIDTH-1:0] serdes_rx_hdr;
    logic [LANES-1:0]           serdes_rx_hdr_valid;
    logic [LANES-1:0]           serdes_rx_bitslip;
    logic [LANES-1:0]           serdes_rx_reset_req;
    logic [LANES-1:0]           rx_block_lock;
    logic                       rx_all_lock;
    logic [LANES*8-1:0]         rx_lock_loss_count;

    modport master (
        output serdes_rx_hdr, serdes_rx_hdr_valid,
        input  serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock,
        input  rx_all_lock, rx_lock_loss_count
    );

    modport slave (
        input  serdes_rx_hdr, serdes_rx_hdr_valid,
        output serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock,
        output rx_all_lock, rx_lock_loss_count
    );
endinterface

// File: rtl/eth_phy_10g_rx_block_lock_ml.sv
// Multi-lane 64b/66b block lock: per-lane sync-header hunt with bitslip,
// lock-loss monitoring, slip-limit SERDES reset request and all-lane lock.
module eth_phy_10g_rx_block_lock_ml #(
    parameter int unsigned LANES               = 4,
    parameter int unsigned HDR_WIDTH           = 2,
    parameter int unsigned SH_WINDOW           = 64,
    parameter int unsigned SH_INVALID_MAX      = 16,
    parameter int unsigned BITSLIP_HIGH_CYCLES = 1,
    parameter int unsigned BITSLIP_LOW_CYCLES  = 8,
    parameter int unsigned SLIP_LIMIT          = 66
) (
    input  logic                         rx_clk,
    input  logic                         rx_rst_n,
    eth_phy_10g_rx_block_lock_ml_if.slave bus
);

    localparam int unsigned SH_W    = $clog2(SH_WINDOW) + 1;
    localparam int unsigned INV_W   = $clog2(SH_INVALID_MAX + 1);
    localparam int unsigned SLIP_W  = $clog2(SLIP_LIMIT + 1);
    localparam int unsigned TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                                      BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKED,
        ST_SLIP_HIGH,
        ST_SLIP_WAIT
    } state_e;

    logic [LANES-1:0] w_lock_vec;
    logic             r_all_lock;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        state_e             r_state, w_state_nxt;
        logic [SH_W-1:0]    r_sh_cnt, w_sh_cnt_nxt;
        logic [INV_W-1:0]   r_inv_cnt, w_inv_cnt_nxt;
        logic [SLIP_W-1:0]  r_slip_cnt, w_slip_cnt_nxt;
        logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
        logic [7:0]         r_llc, w_llc_nxt;
        logic               r_lock, w_lock_nxt;
        logic               r_bitslip, w_bitslip_nxt;
        logic               r_rst_req, w_rst_req_nxt;
        logic               w_slip_start;
        logic [1:0]         w_hdr;
        logic               w_hdr_ok;
        logic               w_qual;

        assign w_hdr    = bus.serdes_rx_hdr[l*HDR_WIDTH +: 2];
        assign w_hdr_ok = w_hdr[1] ^ w_hdr[0];
        assign w_qual   = bus.serdes_rx_hdr_valid[l];

        // Next-state and registered-output decisions for one lane.
        always_comb begin
            w_state_nxt    = r_state;
            w_sh_cnt_nxt   = r_sh_cnt;
            w_inv_cnt_nxt  = r_inv_cnt;
            w_slip_cnt_nxt = r_slip_cnt;
            w_tmr_nxt      = r_tmr;
            w_llc_nxt      = r_llc;
            w_lock_nxt     = r_lock;
            w_rst_req_nxt  = 1'b0;
            w_slip_start   = 1'b0;

            case (r_state)
                ST_UNLOCKED: begin
                    if (w_qual) begin
                        if (!w_hdr_ok) begin
                            w_sh_cnt_nxt = '0;
                            w_slip_start = 1'b1;
                        end else if (r_sh_cnt == SH_W'(SH_WINDOW - 1)) begin
                            w_state_nxt    = ST_LOCKED;
                            w_lock_nxt     = 1'b1;
                            w_sh_cnt_nxt   = '0;
                            w_inv_cnt_nxt  = '0;
                            w_slip_cnt_nxt = '0;
                        end else begin
                            w_sh_cnt_nxt = r_sh_cnt + SH_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    // Loss takes precedence over window completion on the same header.
                    if (w_qual) begin
                        if (!w_hdr_ok && r_inv_cnt == INV_W'(SH_INVALID_MAX - 1)) begin
                            w_lock_nxt    = 1'b0;
                            w_sh_cnt_nxt  = '0;
                            w_inv_cnt_nxt = '0;
                            w_slip_start  = 1'b1;
                            if (r_llc != 8'hFF) w_llc_nxt = r_llc + 8'd1;
                        end else if (r_sh_cnt == SH_W'(SH_WINDOW - 1)) begin
                            w_sh_cnt_nxt  = '0;
                            w_inv_cnt_nxt = '0;
                        end else begin
                            w_sh_cnt_nxt = r_sh_cnt + SH_W'(1);
                            if (!w_hdr_ok) w_inv_cnt_nxt = r_inv_cnt + INV_W'(1);
                        end
                    end
                end
                ST_SLIP_HIGH: begin
                    if (r_tmr == TMR_W'(BITSLIP_HIGH_CYCLES - 1)) begin
                        w_tmr_nxt   = '0;
                        w_state_nxt = ST_SLIP_WAIT;
                    end else begin
                        w_tmr_nxt = r_tmr + TMR_W'(1);
                    end
                end
                ST_SLIP_WAIT: begin
                    if (r_tmr == TMR_W'(BITSLIP_LOW_CYCLES - 1)) begin
                        w_tmr_nxt   = '0;
                        w_state_nxt = ST_UNLOCKED;
                    end else begin
                        w_tmr_nxt = r_tmr + TMR_W'(1);
                    end
                end
                default: w_state_nxt = ST_UNLOCKED;
            endcase

            if (w_slip_start) begin
                w_state_nxt = ST_SLIP_HIGH;
                w_tmr_nxt   = '0;
                if (r_slip_cnt == SLIP_W'(SLIP_LIMIT - 1)) begin
                    w_slip_cnt_nxt = '0;
                    w_rst_req_nxt  = 1'b1;
                end else begin
                    w_slip_cnt_nxt = r_slip_cnt + SLIP_W'(1);
                end
            end

            w_bitslip_nxt = (w_state_nxt == ST_SLIP_HIGH);
        end

        always_ff @(posedge rx_clk or negedge rx_rst_n) begin
            if (!rx_rst_n) begin
                r_state    <= ST_UNLOCKED;
                r_sh_cnt   <= '0;
                r_inv_cnt  <= '0;
                r_slip_cnt <= '0;
                r_tmr      <= '0;
                r_llc      <= '0;
                r_lock     <= 1'b0;
                r_bitslip  <= 1'b0;
                r_rst_req  <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_sh_cnt   <= w_sh_cnt_nxt;
                r_inv_cnt  <= w_inv_cnt_nxt;
                r_slip_cnt <= w_slip_cnt_nxt;
                r_tmr      <= w_tmr_nxt;
                r_llc      <= w_llc_nxt;
                r_lock     <= w_lock_nxt;
                r_bitslip  <= w_bitslip_nxt;
                r_rst_req  <= w_rst_req_nxt;
            end
        end

        assign w_lock_vec[l]                   = r_lock;
        assign bus.rx_block_lock[l]            = r_lock;
        assign bus.serdes_rx_bitslip[l]        = r_bitslip;
        assign bus.serdes_rx_reset_req[l]      = r_rst_req;
        assign bus.rx_lock_loss_count[l*8 +: 8] = r_llc;
    end

    // All-lane lock trails the per-lane lock registers by one cycle.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) r_all_lock <= 1'b0;
        else           r_all_lock <= &w_lock_vec;
    end

    assign bus.rx_all_lock = r_all_lock;

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock_ml.sv
// Randomized bench for the multi-lane block lock, checked against a
// header-counting behavioural model of the lock rules.
module tb_eth_phy_10g_rx_block_lock_ml;

    localparam int unsigned LANES = 4;
    localparam int unsigned HW    = 2;
    localparam int unsigned WIN   = 64;
    localparam int unsigned IMAX  = 16;
    localparam int unsigned BH    = 1;
    localparam int unsigned BL    = 8;
    localparam int unsigned SLIM  = 66;
    localparam int unsigned OW    = 3*LANES + 1 + 8*LANES;

    logic rx_clk = 1'b0;
    logic rx_rst_n;
    always #5 rx_clk = ~rx_clk;

    eth_phy_10g_rx_block_lock_ml_if #(.LANES(LANES), .HDR_WIDTH(HW)) bus();

    eth_phy_10g_rx_block_lock_ml #(
        .LANES(LANES), .HDR_WIDTH(HW), .SH_WINDOW(WIN), .SH_INVALID_MAX(IMAX),
        .BITSLIP_HIGH_CYCLES(BH), .BITSLIP_LOW_CYCLES(BL), .SLIP_LIMIT(SLIM)
    ) u_dut (
        .rx_clk  (rx_clk),
        .rx_rst_n(rx_rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus for the next edge
    logic [1:0] t_hdr[LANES];
    bit         t_vld[LANES];

    // Reference model: headers seen, ignore countdown, slip tally
    bit m_lock[LANES];
    int m_cnt[LANES], m_inv[LANES], m_rem[LANES], m_slips[LANES], m_llc[LANES];
    bit m_bs[LANES], m_rr[LANES];
    bit m_all;

    function automatic logic [1:0] rnd_good();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] rnd_bad();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            m_lock[l] = 0; m_cnt[l] = 0; m_inv[l] = 0; m_rem[l] = 0;
            m_slips[l] = 0; m_llc[l] = 0; m_bs[l] = 0; m_rr[l] = 0;
        end
        m_all = 0;
    endtask

    task automatic model_slip(input int l);
        m_rem[l] = BH + BL;
        m_slips[l]++;
        if (m_slips[l] == SLIM) begin
            m_rr[l] = 1;
            m_slips[l] = 0;
        end
    endtask

    task automatic model_tick();
        bit prev_all = 1;
        bit good;
        for (int l = 0; l < LANES; l++) prev_all &= m_lock[l];
        for (int l = 0; l < LANES; l++) begin
            m_rr[l] = 0;
            good = (t_hdr[l] == 2'b01) || (t_hdr[l] == 2'b10);
            if (m_rem[l] > 0) begin
                m_rem[l]--;
            end else if (t_vld[l]) begin
                if (!m_lock[l]) begin
                    if (!good) begin
                        m_cnt[l] = 0;
                        model_slip(l);
                    end else begin
                        m_cnt[l]++;
                        if (m_cnt[l] == WIN) begin
                            m_lock[l] = 1; m_cnt[l] = 0; m_inv[l] = 0; m_slips[l] = 0;
                        end
                    end
                end else begin
                    m_cnt[l]++;
                    if (!good) m_inv[l]++;
                    if (!good && m_inv[l] == IMAX) begin
                        m_lock[l] = 0; m_cnt[l] = 0; m_inv[l] = 0;
                        if (m_llc[l] < 255) m_llc[l]++;
                        model_slip(l);
                    end else if (m_cnt[l] == WIN) begin
                        m_cnt[l] = 0; m_inv[l] = 0;
                    end
                end
            end
            m_bs[l] = (m_rem[l] > BL);
        end
        m_all = prev_all;
    endtask

    function automatic logic [OW-1:0] exp_vec();
        logic [LANES-1:0]   lk, bs, rr;
        logic [LANES*8-1:0] lc;
        for (int l = 0; l < LANES; l++) begin
            lk[l] = m_lock[l]; bs[l] = m_bs[l]; rr[l] = m_rr[l];
            lc[l*8 +: 8] = 8'(m_llc[l]);
        end
        return {lk, bs, rr, m_all, lc};
    endfunction

    function automatic logic [OW-1:0] obs_vec();
        return {bus.rx_block_lock, bus.serdes_rx_bitslip, bus.serdes_rx_reset_req,
                bus.rx_all_lock, bus.rx_lock_loss_count};
    endfunction

    // Apply stimulus, take one edge, advance the model, settle past the edge.
    task automatic step();
        for (int l = 0; l < LANES; l++) begin
            bus.serdes_rx_hdr[l*HW +: HW] = t_hdr[l];
            bus.serdes_rx_hdr_valid[l]    = t_vld[l];
        end
        @(posedge rx_clk);
        if (!rx_rst_n) model_reset();
        else           model_tick();
        #1;
    endtask

    task automatic do_reset();
        rx_rst_n = 1'b0;
        model_reset();
        for (int l = 0; l < LANES; l++) begin t_vld[l] = 0; t_hdr[l] = 2'b00; end
        step();
        step();
        rx_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int l = 0; l < LANES; l++) begin t_vld[l] = 0; t_hdr[l] = 2'b00; end
        bus.serdes_rx_hdr = '0;
        bus.serdes_rx_hdr_valid = '0;
        rx_rst_n = 1'b1;
        #1 rx_rst_n = 1'b0;
        model_reset();
        #1;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset_async got=%h exp=0", obs_vec());
        end
        checks++;
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < LANES; l++) begin t_vld[l] = 1; t_hdr[l] = 2'($urandom); end
            step();
            if (obs_vec() !== '0) begin
                errors++; $display("FAIL reset_hold cyc=%0d got=%h exp=0", c, obs_vec());
            end
            checks++;
        end
        rx_rst_n = 1'b1;
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 100; c++) begin
            for (int l = 0; l < LANES; l++) begin
                t_hdr[l] = rnd_good();
                t_vld[l] = (c >= l*5);
            end
            step();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL lock_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (c == 62 || c == 63) begin
                if (bus.rx_block_lock[0] !== (c == 63)) begin
                    errors++; $display("FAIL lock0_edge cyc=%0d got=%b exp=%b", c, bus.rx_block_lock[0], c == 63);
                end
                checks++;
            end
            if (c == 78 || c == 79) begin
                if (bus.rx_all_lock !== (c == 79)) begin
                    errors++; $display("FAIL all_lock_edge cyc=%0d got=%b exp=%b", c, bus.rx_all_lock, c == 79);
                end
                checks++;
            end
        end
    endtask

    task automatic test_slip();
        do_reset();
        for (int c = 0; c < 140; c++) begin
            for (int l = 0; l < LANES; l++) begin t_hdr[l] = rnd_good(); t_vld[l] = 1; end
            if (c == 63) t_hdr[0] = 2'b00;
            else if (c > 63 && c <= 72) t_hdr[0] = 2'($urandom);
            step();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL slip_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (c >= 63 && c <= 72) begin
                if (bus.serdes_rx_bitslip[0] !== (c == 63) || bus.rx_block_lock[0] !== 1'b0) begin
                    errors++; $display("FAIL slip_pulse cyc=%0d got_bs=%b exp_bs=%b lock=%b",
                                       c, bus.serdes_rx_bitslip[0], c == 63, bus.rx_block_lock[0]);
                end
                checks++;
            end
            if (c == 135 || c == 136) begin
                if (bus.rx_block_lock[0] !== (c == 136)) begin
                    errors++; $display("FAIL slip_relock cyc=%0d got=%b exp=%b", c, bus.rx_block_lock[0], c == 136);
                end
                checks++;
            end
        end
    endtask

    task automatic test_loss();
        bit inv_pos[64];
        int n = 0;
        for (int i = 0; i < 64; i++) inv_pos[i] = 0;
        while (n < 15) begin
            int p = $urandom_range(0, 49);
            if (!inv_pos[p]) begin inv_pos[p] = 1; n++; end
        end
        do_reset();
        for (int c = 0; c < 64 + 85; c++) begin
            int idx = c - 64;
            for (int l = 0; l < LANES; l++) begin t_hdr[l] = rnd_good(); t_vld[l] = 1; end
            if (idx >= 0 && ((idx < 64 && inv_pos[idx]) || idx == 55)) t_hdr[0] = rnd_bad();
            if (idx >= 0 && (idx < 15 || (idx >= 64 && idx < 79))) t_hdr[1] = rnd_bad();
            step();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL loss_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (idx == 54 && bus.rx_block_lock[0] !== 1'b1) begin
                errors++; $display("FAIL loss_15_kept got=%b exp=1", bus.rx_block_lock[0]);
            end
            if (idx == 54) checks++;
            if (idx == 55) begin
                if (bus.rx_block_lock[0] !== 1'b0 || bus.rx_lock_loss_count[7:0] !== 8'd1 ||
                    bus.serdes_rx_bitslip[0] !== 1'b1) begin
                    errors++; $display("FAIL loss_16th got lock=%b cnt=%0d bs=%b exp lock=0 cnt=1 bs=1",
                                       bus.rx_block_lock[0], bus.rx_lock_loss_count[7:0], bus.serdes_rx_bitslip[0]);
                end
                checks++;
            end
            if (idx == 84) begin
                if (bus.rx_block_lock[1] !== 1'b1 || bus.rx_lock_loss_count[15:8] !== 8'd0) begin
                    errors++; $display("FAIL loss_window_clear got lock=%b cnt=%0d exp lock=1 cnt=0",
                                       bus.rx_block_lock[1], bus.rx_lock_loss_count[15:8]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_gaps();
        int q[LANES];
        bit seen[LANES];
        for (int l = 0; l < LANES; l++) begin q[l] = 0; seen[l] = 0; end
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int l = 0; l < LANES; l++) begin
                t_hdr[l] = rnd_good();
                t_vld[l] = $urandom_range(0, 1) == 1;
                if (t_vld[l] && !seen[l]) q[l]++;
            end
            step();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL gaps_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            for (int l = 0; l < LANES; l++) begin
                if (!seen[l] && bus.rx_block_lock[l] === 1'b1) begin
                    seen[l] = 1;
                    if (q[l] != 64) begin
                        errors++; $display("FAIL gaps_qual_count lane=%0d got=%0d exp=64", l, q[l]);
                    end
                    checks++;
                end
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (!seen[l]) begin
                errors++; $display("FAIL gaps_timeout lane=%0d got=unlocked exp=locked", l);
            end
            checks++;
        end
    endtask

    task automatic test_slip_limit();
        int  n_slip = 0;
        bit  prev_bs = 0;
        bit  seen = 0;
        int  post = 0;
        do_reset();
        for (int c = 0; c < 1000 && post < 5; c++) begin
            for (int l = 0; l < LANES; l++) begin t_hdr[l] = rnd_good(); t_vld[l] = 1; end
            t_hdr[2] = 2'b11;
            step();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL slimit_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (bus.serdes_rx_bitslip[2] && !prev_bs) n_slip++;
            prev_bs = bus.serdes_rx_bitslip[2];
            if (seen) post++;
            if (!seen && bus.serdes_rx_reset_req[2] === 1'b1) begin
                seen = 1;
                if (n_slip != 66 || bus.serdes_rx_reset_req !== 4'b0100 ||
                    bus.rx_block_lock !== 4'b1011) begin
                    errors++; $display("FAIL slimit_pulse got slips=%0d rr=%b lock=%b exp slips=66 rr=0100 lock=1011",
                                       n_slip, bus.serdes_rx_reset_req, bus.rx_block_lock);
                end
                checks++;
            end
        end
        if (!seen) begin
            errors++; $display("FAIL slimit_timeout got=no_reset_req exp=reset_req slips=%0d", n_slip);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int l = 0; l < LANES; l++) begin t_hdr[l] = rnd_bad(); t_vld[l] = 1; end
        step();
        if (bus.serdes_rx_bitslip !== 4'hF) begin
            errors++; $display("FAIL arst_pre_bs got=%b exp=1111", bus.serdes_rx_bitslip);
        end
        checks++;
        #2 rx_rst_n = 1'b0;
        #1;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL arst_immediate got=%h exp=0", obs_vec());
        end
        checks++;
        model_reset();
        step();
        rx_rst_n = 1'b1;
        for (int c = 0; c < 70; c++) begin
            for (int l = 0; l < LANES; l++) begin t_hdr[l] = rnd_good(); t_vld[l] = 1; end
            step();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL arst_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (c == 62 || c == 63) begin
                if (bus.rx_block_lock !== ((c == 63) ? 4'hF : 4'h0)) begin
                    errors++; $display("FAIL arst_relock cyc=%0d got=%b", c, bus.rx_block_lock);
                end
                checks++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int l = 0; l < LANES; l++) begin
                int sel = ((c / 300) + l) % 3;
                bit bad = (sel == 1) ? ($urandom_range(0, 15) == 0) :
                          (sel == 2) ? ($urandom_range(0, 1) == 0) : 1'b0;
                t_hdr[l] = bad ? rnd_bad() : rnd_good();
                t_vld[l] = $urandom_range(0, 4) != 0;
            end
            step();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int it = 0; it < 258; it++) begin
            for (int k = 0; k < 89; k++) begin
                for (int l = 0; l < LANES; l++) begin
                    t_hdr[l] = (k < 64) ? rnd_good() : (k < 80) ? rnd_bad() : 2'($urandom);
                    t_vld[l] = 1;
                end
                step();
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL sat_model it=%0d k=%0d got=%h exp=%h", it, k, obs_vec(), exp_vec());
                end
                checks++;
            end
        end
        if (bus.rx_lock_loss_count !== {LANES{8'd255}}) begin
            errors++; $display("FAIL sat_final got=%h exp=all_ff", bus.rx_lock_loss_count);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_slip();
        test_loss();
        test_gaps();
        test_slip_limit();
        test_async_reset();
        test_random();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
